button_debouncer: RTL and testbench

Debounces one mechanical push-button input and emits a clean level plus single-cycle press/release pulses. Sits directly downstream of the free-running tick counter: that counter's one-cycle `counter_match` pulse drives `sample_tick`, which sets the sampling rate, e.g. 1 ms. Outputs feed user-logic counters and FSMs that need exactly one event per physical press.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/input_synchronizer.sv | 28 ++
 rtl/button_debouncer.sv | 137 +++++++++++++
 tb/tb_button_debouncer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the pin-input debouncing blocks: state encoding and
// the sample-counter width helper.
package debounce_pkg;

  localparam logic [1:0] ST_RELEASED   = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_REL_PEND   = 2'd3;

  typedef enum logic [1:0] {
    RELEASED   = ST_RELEASED,
    PRESS_PEND = ST_PRESS_PEND,
    PRESSED    = ST_PRESSED,
    REL_PEND   = ST_REL_PEND
  } deb_state_e;

  // Bits needed to hold a count of 0..samples inclusive.
  function automatic int cnt_width(input int samples);
    return $clog2(samples + 1);
  endfunction

endpackage

// File: rtl/input_synchronizer.sv
// N-flop synchronizer for an asynchronous pin; the reset value is a parameter
// so a chain can come out of reset already holding the pin's idle level.
module input_synchronizer #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_a_p,
  input  logic d_i,
  output logic q_o
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;

  // Shift the raw pin through the metastability chain.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      sync_q <= {N{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one push-button: synchronizes the pin, then accepts a new state
// only after STABLE_SAMPLES consecutive agreeing samples on sample_tick.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4,
  parameter int ACTIVE_LOW     = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst_a_p,
  input  logic sample_tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int            CW         = cnt_width(STABLE_SAMPLES);
  localparam logic [CW:0]   TARGET     = (CW + 1)'(STABLE_SAMPLES);
  localparam bit            ONE_SAMPLE = (STABLE_SAMPLES == 1);
  localparam logic          INVERT     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);

  logic          btn_sync_s;
  logic          btn_s;
  logic          cnt_done_s;
  logic [CW-1:0] cnt_inc_s;

  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;

  // The chain resets to the idle pin level so reset release is never a press.
  input_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (INVERT)
  ) u_sync (
    .clk     (clk),
    .rst_a_p (rst_a_p),
    .d_i     (btn_raw),
    .q_o     (btn_sync_s)
  );

  assign btn_s      = btn_sync_s ^ INVERT;
  assign cnt_inc_s  = cnt_q + CNT_ONE;
  assign cnt_done_s = (({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1}) == TARGET);

  // Debounce FSM with counter and registered level/pulse outputs.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (sample_tick) begin
        case (state_q)
          RELEASED: begin
            if (btn_s) begin
              if (ONE_SAMPLE) begin
                state_q <= PRESSED;
                cnt_q   <= '0;
                level_q <= 1'b1;
                press_q <= 1'b1;
              end else begin
                state_q <= PRESS_PEND;
                cnt_q   <= CNT_ONE;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          PRESS_PEND: begin
            if (btn_s && cnt_done_s) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else if (btn_s) begin
              cnt_q <= cnt_inc_s;
            end else begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end
          end
          PRESSED: begin
            if (!btn_s) begin
              if (ONE_SAMPLE) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                release_q <= 1'b1;
              end else begin
                state_q <= REL_PEND;
                cnt_q   <= CNT_ONE;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          REL_PEND: begin
            if (!btn_s && cnt_done_s) begin
              state_q   <= RELEASED;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else if (!btn_s) begin
              cnt_q <= cnt_inc_s;
            end else begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end else begin
        state_q <= state_q;
        cnt_q   <= cnt_q;
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer against a run-length
// model of the accepted button state.
module tb_button_debouncer;

  localparam int SS = 4;

  logic clk = 1'b0;
  logic rst_a_p;
  logic sample_tick;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: pin pipeline, accepted level, length of the current disagreeing run.
  logic ph1, ph2;
  logic e_level, e_press, e_rel;
  int   run;

  int press_cnt, rel_cnt, tick_cnt, press_tick, rel_tick;

  button_debouncer #(
    .STABLE_SAMPLES (SS),
    .ACTIVE_LOW     (1),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst_a_p     (rst_a_p),
    .sample_tick (sample_tick),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    ph1 = 1'b1; ph2 = 1'b1;
    e_level = 1'b0; e_press = 1'b0; e_rel = 1'b0;
    run = 0;
  endtask

  task automatic clr_stats();
    press_cnt = 0; rel_cnt = 0; tick_cnt = 0; press_tick = -1; rel_tick = -1;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic raw, input logic tick);
    logic s;
    btn_raw = raw;
    sample_tick = tick;
    @(posedge clk);
    if (rst_a_p) begin
      m_reset();
    end else begin
      s = ~ph2;
      ph2 = ph1;
      ph1 = raw;
      e_press = 1'b0;
      e_rel = 1'b0;
      if (tick) begin
        if (s != e_level) begin
          run++;
          if (run == SS) begin
            e_level = s;
            e_press = s;
            e_rel = ~s;
            run = 0;
          end
        end else begin
          run = 0;
        end
      end
    end
    if (tick) tick_cnt++;
    #1;
    chk("btn_level", btn_level, e_level);
    chk("btn_press", btn_press, e_press);
    chk("btn_release", btn_release, e_rel);
    if (btn_press) begin
      press_cnt++;
      if (press_tick < 0) press_tick = tick_cnt;
    end
    if (btn_release) begin
      rel_cnt++;
      if (rel_tick < 0) rel_tick = tick_cnt;
    end
    cyc++;
  endtask

  task automatic auto_step(input logic raw);
    step(raw, (cyc % 10) == 9);
  endtask

  task automatic align(input logic raw);
    while ((cyc % 10) != 0) auto_step(raw);
  endtask

  task automatic play(input logic v);
    repeat (10) auto_step(v);
  endtask

  initial begin
    logic target;
    int   bounce;
    int   tickp;
    logic raw;
    logic [6:0] bounce_seq;
    logic [5:0] rel_seq;

    rst_a_p = 1'b1;
    btn_raw = 1'b1;
    sample_tick = 1'b0;
    m_reset();
    clr_stats();

    // Long reset with the pin idle; nothing may fire afterwards either.
    repeat (200) auto_step(1'b1);
    rst_a_p = 1'b0;
    repeat (30) auto_step(1'b1);
    chk("no_pulse_after_reset", press_cnt + rel_cnt, 0);

    // Clean press: pulse right after the 4th tick seeing the pin low.
    align(1'b1);
    clr_stats();
    repeat (60) auto_step(1'b0);
    chk("clean_press_count", press_cnt, 1);
    chk("clean_press_tick", press_tick, 4);
    chk("clean_press_no_release", rel_cnt, 0);
    chk("clean_press_level", btn_level, 1);

    // Release with bounce: samples 1,0,1,1,1,1.
    clr_stats();
    rel_seq = 6'b111101;
    for (int i = 0; i < 6; i++) play(rel_seq[i]);
    chk("bounce_release_count", rel_cnt, 1);
    chk("bounce_release_tick", rel_tick, 6);
    chk("bounce_release_no_press", press_cnt, 0);
    chk("bounce_release_level", btn_level, 0);

    // Press with bounce: samples 0,0,1,0,0,0,0.
    clr_stats();
    bounce_seq = 7'b0000100;
    for (int i = 0; i < 7; i++) play(bounce_seq[i]);
    chk("bounce_press_count", press_cnt, 1);
    chk("bounce_press_tick", press_tick, 7);
    repeat (60) auto_step(1'b1);

    // Reset while three samples into a pending press.
    align(1'b1);
    clr_stats();
    repeat (30) auto_step(1'b0);
    repeat (2) auto_step(1'b0);
    rst_a_p = 1'b1;
    #1;
    chk("rst_pend_level", btn_level, 0);
    chk("rst_pend_press", btn_press, 0);
    chk("rst_pend_release", btn_release, 0);
    repeat (8) auto_step(1'b0);
    rst_a_p = 1'b0;
    clr_stats();
    repeat (60) auto_step(1'b0);
    chk("rst_pend_press_count", press_cnt, 1);
    chk("rst_pend_press_tick", press_tick, 4);

    // Reset from PRESSED drops the level without waiting for a clock.
    rst_a_p = 1'b1;
    #1;
    chk("rst_pressed_level", btn_level, 0);
    repeat (3) auto_step(1'b1);
    rst_a_p = 1'b0;

    // No ticks: pin activity must never reach the outputs.
    clr_stats();
    for (int i = 0; i < 500; i++) step(1'(($urandom_range(0, 1))), 1'b0);
    chk("no_tick_pulses", press_cnt + rel_cnt, 0);
    chk("no_tick_level", btn_level, 0);

    // Randomized bouncing pin, varying tick density, occasional reset.
    target = 1'b1;
    bounce = 0;
    tickp = 3;
    for (int i = 0; i < 15000; i++) begin
      if ((i % 2000) == 0) tickp = $urandom_range(1, 6);
      if ($urandom_range(0, 59) == 0) begin
        target = ~target;
        bounce = $urandom_range(0, 12);
      end
      if (bounce > 0) begin
        raw = 1'($urandom_range(0, 1));
        bounce--;
      end else begin
        raw = target;
      end
      if ($urandom_range(0, 2999) == 0) begin
        rst_a_p = 1'b1;
        #1;
        chk("rand_rst_level", btn_level, 0);
        repeat (2) step(raw, 1'b1);
        rst_a_p = 1'b0;
      end
      step(raw, $urandom_range(1, tickp) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
